fib_scan_ctrl: RTL and testbench



---
 rtl/fib_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_fib_scan_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_scan_ctrl.sv
// Exhaustive on-chip checker for the N-bit Fibonacci-membership detectors.
// Sweeps x over 0..2^N-1 and compares the three detectors against a running Fibonacci reference.
module fib_scan_ctrl #(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         o_b,
  input  logic         o_g,
  input  logic         o_d,
  output logic [N-1:0] x,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   fib_cnt,
  output logic [N-1:0] err_idx,
  output logic [2:0]   err_mask
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_ADV,
    S_DONE
  } state_t;

  localparam logic [3:0]   SETTLE_L = 4'(SETTLE);
  localparam logic [N-1:0] X_LAST   = {N{1'b1}};
  localparam logic [N-1:0] X_ONE    = {{(N-1){1'b0}}, 1'b1};

  state_t       r_state;
  logic [N+1:0] r_f_cur;
  logic [N+1:0] r_f_nxt;
  logic [3:0]   r_settle;

  logic         w_ref;
  logic [2:0]   w_mism;
  logic         w_step;
  logic         w_last;

  // The reference term trails x: it is the smallest sequence term not yet passed.
  assign w_ref  = ({2'b00, x} == r_f_cur);
  assign w_mism = {o_b ^ w_ref, o_g ^ w_ref, o_d ^ w_ref};
  assign w_step = (r_f_cur <= {2'b00, x});
  assign w_last = (x == X_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_f_cur  <= '0;
      r_f_nxt  <= '0;
      r_settle <= '0;
      x        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fib_cnt  <= '0;
      err_idx  <= '0;
      err_mask <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            x        <= '0;
            r_f_cur  <= '0;
            r_f_nxt  <= {{(N+1){1'b0}}, 1'b1};
            fib_cnt  <= '0;
            err_idx  <= '0;
            err_mask <= '0;
            pass     <= 1'b1;
            r_settle <= SETTLE_L;
            busy     <= 1'b1;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_settle == 4'd1) begin
            r_state <= S_CHECK;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        S_CHECK: begin
          if (w_mism != 3'b000) begin
            err_idx  <= x;
            err_mask <= w_mism;
            pass     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            fib_cnt <= fib_cnt + (N+1)'(w_ref);
            r_state <= S_ADV;
          end
        end
        S_ADV: begin
          // One reference step per cycle; the repeated term 1 costs two steps at x=1.
          if (w_step) begin
            r_f_cur <= r_f_nxt;
            r_f_nxt <= r_f_cur + r_f_nxt;
          end else if (w_last) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            x        <= x + X_ONE;
            r_settle <= SETTLE_L;
            r_state  <= S_WAIT;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_scan_ctrl.sv
// Randomized bench for fib_scan_ctrl: behavioural detectors with injectable faults and a
// closed-form reference model of the sweep outcome and cycle-by-cycle timing.
module tb_fib_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start    [2];
  logic       ob       [2];
  logic       og       [2];
  logic       od       [2];
  logic [3:0] x        [2];
  logic       busy     [2];
  logic       done     [2];
  logic       pass     [2];
  logic [4:0] fib_cnt  [2];
  logic [3:0] err_idx  [2];
  logic [2:0] err_mask [2];

  int         f_idx   [2];
  logic [2:0] f_mask  [2];
  bit         g_stuck [2];
  bit         frc_en;
  logic [2:0] frc_val;

  int n_chk;
  int n_err;

  int exp_run [16];
  int obs_run [16];
  bit exp_pass;
  int exp_cnt, exp_idx, exp_mask, exp_done, exp_last;

  fib_scan_ctrl #(.N(4), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .o_b(ob[0]), .o_g(og[0]), .o_d(od[0]),
    .x(x[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fib_cnt(fib_cnt[0]),
    .err_idx(err_idx[0]), .err_mask(err_mask[0])
  );

  fib_scan_ctrl #(.N(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .o_b(ob[1]), .o_g(og[1]), .o_d(od[1]),
    .x(x[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fib_cnt(fib_cnt[1]),
    .err_idx(err_idx[1]), .err_mask(err_mask[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_fib(input int v);
    int a, b, t;
    a = 0; b = 1;
    while (a <= v) begin
      if (a == v) return 1'b1;
      t = a + b; a = b; b = t;
    end
    return 1'b0;
  endfunction

  // Number of sequence terms 0,1,1,2,3,5,... that are <= v.
  function automatic int cnt_le(input int v);
    int a, b, t, c;
    a = 0; b = 1; c = 0;
    while (a <= v) begin
      c++;
      t = a + b; a = b; b = t;
    end
    return c;
  endfunction

  function automatic logic [2:0] det(input logic [3:0] xv, input int fi, input logic [2:0] fm,
                                     input bit gs, input bit fe, input logic [2:0] fv);
    logic [2:0] r;
    if (fe) return fv;
    r = {3{is_fib(int'(xv))}};
    if (int'(xv) == fi) r = r ^ fm;
    if (gs) r[1] = 1'b0;
    return r;
  endfunction

  assign {ob[0], og[0], od[0]} = det(x[0], f_idx[0], f_mask[0], g_stuck[0], frc_en, frc_val);
  assign {ob[1], og[1], od[1]} = det(x[1], f_idx[1], f_mask[1], g_stuck[1], frc_en, frc_val);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int d);
    int s, cyc, r, k;
    logic [2:0] m;
    s = (d == 1) ? 3 : 1;
    exp_pass = 1'b1; exp_cnt = 0; exp_idx = 0; exp_mask = 0; exp_last = 0; cyc = 0;
    for (int v = 0; v < 16; v++) exp_run[v] = 0;
    for (int v = 0; v < 16; v++) begin
      r = int'(is_fib(v));
      m = det(4'(v), f_idx[d], f_mask[d], g_stuck[d], 1'b0, 3'b000) ^ {3{r[0]}};
      exp_last = v;
      if (m != 3'b000) begin
        exp_pass = 1'b0; exp_idx = v; exp_mask = int'(m);
        exp_run[v] = s + 1;
        cyc += s + 1;
        break;
      end
      exp_cnt += r;
      k = cnt_le(v) - ((v == 0) ? 0 : cnt_le(v - 1));
      exp_run[v] = s + 2 + k;
      cyc += exp_run[v];
    end
    exp_done = cyc + 1;
  endtask

  task automatic chk_rst(input int d, input string tag);
    chk({tag, ".x"}, 32'(x[d]), 0);
    chk({tag, ".busy"}, 32'(busy[d]), 0);
    chk({tag, ".done"}, 32'(done[d]), 0);
    chk({tag, ".pass"}, 32'(pass[d]), 0);
    chk({tag, ".fib_cnt"}, 32'(fib_cnt[d]), 0);
    chk({tag, ".err_idx"}, 32'(err_idx[d]), 0);
    chk({tag, ".err_mask"}, 32'(err_mask[d]), 0);
  endtask

  task automatic run_scan(input int d, input bit hold, input string tag);
    int cyc, busy_cnt, bad_step, later;
    bit got;
    logic [3:0] prev;
    model(d);
    for (int v = 0; v < 16; v++) obs_run[v] = 0;
    cyc = 0; busy_cnt = 0; bad_step = 0; got = 1'b0; prev = 4'd0;
    @(negedge clk);
    start[d] = 1'b1;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!hold) start[d] = 1'b0;
      if (busy[d]) begin
        busy_cnt++;
        obs_run[x[d]]++;
        if (x[d] != prev && x[d] != prev + 4'd1) bad_step++;
        prev = x[d];
      end
      if (done[d]) got = 1'b1;
    end
    if (!got) begin
      chk({tag, ".timeout"}, 32'(cyc), 32'(exp_done));
      start[d] = 1'b0;
      return;
    end
    chk({tag, ".done_cycle"}, 32'(cyc), 32'(exp_done));
    chk({tag, ".pass"}, 32'(pass[d]), 32'(exp_pass));
    chk({tag, ".fib_cnt"}, 32'(fib_cnt[d]), 32'(exp_cnt));
    chk({tag, ".err_idx"}, 32'(err_idx[d]), 32'(exp_idx));
    chk({tag, ".err_mask"}, 32'(err_mask[d]), 32'(exp_mask));
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_done - 1));
    chk({tag, ".busy_at_done"}, 32'(busy[d]), 0);
    chk({tag, ".x_order"}, 32'(bad_step), 0);
    for (int v = 0; v <= exp_last; v++)
      chk($sformatf("%s.x_hold[%0d]", tag, v), 32'(obs_run[v]), 32'(exp_run[v]));
    later = 0;
    for (int v = exp_last + 1; v < 16; v++) later += obs_run[v];
    chk({tag, ".later_idx"}, 32'(later), 0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done[d]), 0);
    chk({tag, ".pass_hold"}, 32'(pass[d]), 32'(exp_pass));
  endtask

  task automatic clr_faults();
    for (int d = 0; d < 2; d++) begin
      f_idx[d] = -1; f_mask[d] = 3'b000; g_stuck[d] = 1'b0;
    end
  endtask

  initial begin
    int d, tries;
    n_chk = 0; n_err = 0;
    clr_faults();
    frc_en = 1'b1; frc_val = 3'b000;
    start[0] = 1'b0; start[1] = 1'b0;
    rst_n = 1'b0;

    // Reset with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start[0] = 1'($urandom); start[1] = 1'($urandom);
      frc_val = 3'($urandom);
      @(negedge clk);
      chk_rst(0, "rst1"); chk_rst(1, "rst3");
    end
    start[0] = 1'b0; start[1] = 1'b0; frc_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle.busy", 32'(busy[0]), 0);
    chk("idle.done", 32'(done[0]), 0);
    chk("idle.x", 32'(x[0]), 0);

    // Correct detectors, SETTLE=1: done at cycle 57, fib_cnt=7.
    run_scan(0, 1'b0, "good1");
    chk("good1.cycle57", 32'(exp_done), 57);

    // o_g stuck low fails at x=0.
    clr_faults(); g_stuck[0] = 1'b1;
    run_scan(0, 1'b0, "gstuck");

    // o_d additionally asserts at x=4.
    clr_faults(); f_idx[0] = 4; f_mask[0] = 3'b001;
    run_scan(0, 1'b0, "dat4");

    // Random single-index faults on either instance.
    for (int i = 0; i < 8; i++) begin
      clr_faults();
      d = int'($urandom_range(0, 1));
      f_idx[d] = int'($urandom_range(0, 15));
      f_mask[d] = 3'($urandom_range(0, 7));
      run_scan(d, 1'b0, $sformatf("rnd%0d", i));
    end
    clr_faults();

    // start held high: one scan, then a fresh scan from IDLE.
    run_scan(0, 1'b1, "hold");
    @(negedge clk);
    chk("hold.rescan_busy", 32'(busy[0]), 1);
    chk("hold.rescan_x", 32'(x[0]), 0);
    start[0] = 1'b0;
    tries = 0;
    while (!done[0] && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    chk("hold.second_done", 32'(done[0]), 1);
    @(negedge clk);

    // Asynchronous reset mid-scan at x=7.
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    tries = 0;
    while (x[0] != 4'd7 && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    chk("midrst.reach7", 32'(x[0]), 7);
    #1 rst_n = 1'b0;
    #1 chk_rst(0, "midrst");
    repeat (3) begin
      @(negedge clk);
      chk("midrst.no_done", 32'(done[0]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.idle", 32'(busy[0]), 0);
    run_scan(0, 1'b0, "after_rst");

    // SETTLE=3 instance, correct detectors: done at cycle 89.
    run_scan(1, 1'b0, "good3");
    chk("good3.cycle89", 32'(exp_done), 89);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
